prod_accum_7: RTL
=================

# prod_accum_7

Downstream consumer of the 4x4 multiplier datapath. It accepts a burst of 8-bit products over a valid/ready handshake and sums them into a saturating 12-bit accumulator. When the burst is complete, it presents the total on an output handshake. One instance sits after each multiplier FSM, turning a stream of products into a dot-product result.

## Interface
Parameters:
- PW, 8, product (input data) width
- AW, 12, accumulator/result width; must satisfy AW > PW
- LW, 8, burst-length field width

Ports:
- clk  in  1  single clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a burst; sampled only in IDLE
- len  in  LW  burst length, sampled with start; 0 means 2^LW (256) beats
- p_valid  in  1  product beat valid
- p_data  in  PW  product value, unsigned
- p_ready  out  1  block can accept a product beat
- acc_valid  out  1  result valid
- acc_data  out  AW  accumulated sum, unsigned
- acc_ready  in  1  consumer accepts result
- ovf  out  1  saturation occurred in this burst; valid with acc_valid
- busy  out  1  high in any state other than IDLE

## Operation
- States:
  - IDLE: waiting for start
  - ACCUM: consuming product beats
  - DONE: holding the result for the consumer
- Encoding: 2-bit enum; IDLE=0, ACCUM=1, DONE=2. Encoding 3 is illegal and decodes to IDLE next cycle.
- IDLE:
  - p_ready=0, acc_valid=0.
  - On start=1: clear acc to 0 and ovf to 0, load remaining count to len (9-bit; len=0 loads 256), then go to ACCUM.
- ACCUM:
  - p_ready=1.
  - Beat: p_valid&p_ready.
  - On each beat: acc ← sat(acc + zero-extended p_data), decrement the count.
  - If the AW-bit sum would exceed 2^AW−1, acc = 2^AW−1 (4095) and ovf ← 1 (sticky for the burst).
  - Beat with count==1: go to DONE.
  - No beat: hold everything.
- DONE:
  - acc_valid=1; acc_data and ovf are stable until transfer.
  - Transfer (acc_valid&acc_ready): go to IDLE.
  - acc_data and ovf keep their last values in IDLE; they are cleared only by the next start or by rst.
- start is ignored outside IDLE. Any p_valid outside ACCUM is not accepted, because p_ready=0.
- Arithmetic: unsigned throughout; the saturating add is computed at AW+1 bits, then clamped.

## Timing
- Reset values: state=IDLE, acc_data=0, ovf=0, p_ready=0, acc_valid=0, busy=0.
- rst asserted mid-burst or in DONE: the block returns immediately to IDLE, accumulated data is discarded, and no result is produced.
- Latency:
  - start in cycle t → p_ready=1 in cycle t+1.
  - Last beat accepted in cycle t → acc_valid=1 in cycle t+1, with acc_data including that beat.
- Throughput: one beat per cycle in ACCUM; back-to-back beats are accepted without bubbles.
- All outputs are registered or decoded from state only. There are no combinational paths from p_valid, acc_ready or start to any output.
- Back-to-back bursts:
  - The transfer cycle in DONE moves to IDLE.
  - start is accepted in the following cycle.
  - Minimum gap between acc transfer and the next p_ready is 2 cycles.
- Simultaneous events:
  - start asserted in the same cycle as a DONE transfer is ignored, because the state is not yet IDLE.
  - In ACCUM, a p_valid arriving with count==1 is the final beat; no extra beat is taken.

## Structure
- Package prod_accum_pkg holds:
  - state enum (IDLE/ACCUM/DONE)
  - default PW/AW/LW constants
  - function for the len==0 → 256 mapping
- Sub-module sat_add_7: combinational AW-bit unsigned saturating adder.
  - Inputs: acc[AW-1:0], addend[PW-1:0].
  - Outputs: sum[AW-1:0], sat.
  - Instantiated once; the FSM, counter and registers live in prod_accum_7.

## Test plan
- Reset then idle: rst pulse → all outputs 0; p_valid=1 with no start → p_ready stays 0, no beat taken.
- Basic burst: start, len=4; beats 225, 1, 9, 16 back-to-back → acc_valid one cycle after the 4th beat, acc_data=251, ovf=0; acc_ready=1 → IDLE next cycle.
- Stalls: len=3; beats 10, 20, 30 with p_valid gaps of 0, 2, 1 cycles and acc_ready held low for 5 cycles → acc_data=60 held stable for the whole stall, busy=1 throughout.
- Saturation with len=0: 256 beats of 225 (sum 57600) → acc_data=4095, ovf=1, and it stays 4095 after crossing.
- Reset mid-burst: len=5, 2 beats of 100, assert rst → IDLE with acc_data=0. A new start with len=1 and beat 7 → acc_data=7, ovf=0.
- Start-on-transfer: in DONE, assert start with acc_ready in the same cycle → start ignored, IDLE. start in the next cycle with len=1 → p_ready rises the cycle after.

Source files
------------

// File: rtl/prod_accum_pkg.sv
// Shared types and defaults for the product accumulator block.
package prod_accum_pkg;

    // Default widths: 8-bit products, 12-bit accumulator, 8-bit burst length.
    localparam int PW_DEF = 8;
    localparam int AW_DEF = 12;
    localparam int LW_DEF = 8;

    // Controller states; encoding 3 is unused and recovers to IDLE.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Number of beats in a burst: a zero length field means the full
    // 2^lw beats, so the count register needs one bit more than len.
    function automatic int unsigned burst_beats(input int unsigned len,
                                                input int unsigned lw);
        return (len == 0) ? (32'd1 << lw) : len;
    endfunction

endpackage

// File: rtl/sat_add_7.sv
// Combinational unsigned saturating adder: acc + zero-extended addend,
// clamped to all-ones when the sum does not fit in AW bits.
module sat_add_7
    import prod_accum_pkg::*;
#(
    parameter int PW = PW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic [AW-1:0] acc,
    input  logic [PW-1:0] addend,
    output logic [AW-1:0] sum,
    output logic          sat
);

    logic [AW:0] wide;

    // Add one bit wider than the accumulator so the carry-out is the
    // saturation flag, then clamp.
    // NOTE: every output of this block is assigned on every pass, so no
    // latch can be inferred.
    always_comb begin
        wide = {1'b0, acc} + (AW + 1)'(addend);
        sat  = wide[AW];
        sum  = sat ? '1 : wide[AW-1:0];
    end

endmodule

// File: rtl/prod_accum_7.sv
// Burst accumulator: takes LW-sized bursts of PW-bit unsigned products over
// a valid/ready handshake, sums them with saturation into an AW-bit total,
// and offers the total (with a sticky overflow flag) on an output handshake.
// All outputs are flops, so nothing combinational reaches them from
// start, p_valid or acc_ready.
module prod_accum_7
    import prod_accum_pkg::*;
#(
    parameter int PW = PW_DEF,
    parameter int AW = AW_DEF,   // must be larger than PW
    parameter int LW = LW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [LW-1:0] len,
    input  logic          p_valid,
    input  logic [PW-1:0] p_data,
    output logic          p_ready,
    output logic          acc_valid,
    output logic [AW-1:0] acc_data,
    input  logic          acc_ready,
    output logic          ovf,
    output logic          busy
);

    // Remaining-beat counter is one bit wider than len so it can hold 2^LW.
    localparam int CW = LW + 1;

    state_t        state;
    logic [CW-1:0] count;
    logic [AW-1:0] sum_next;
    logic          sat_next;
    logic          beat;
    logic          last_beat;

    // p_ready is high exactly while in ACCUM, so a beat can only land there.
    assign beat      = p_valid & p_ready;
    assign last_beat = (count == CW'(1));

    // The single saturating adder always sees the running total.
    sat_add_7 #(
        .PW (PW),
        .AW (AW)
    ) u_sat_add (
        .acc    (acc_data),
        .addend (p_data),
        .sum    (sum_next),
        .sat    (sat_next)
    );

    // Controller, beat counter and result registers. The handshake and busy
    // outputs are registered alongside the state they decode.
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            acc_data  <= '0;
            ovf       <= 1'b0;
            p_ready   <= 1'b0;
            acc_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc_data <= '0;
                        ovf      <= 1'b0;
                        count    <= CW'(burst_beats(32'(len), LW));
                        state    <= ACCUM;
                        p_ready  <= 1'b1;
                        busy     <= 1'b1;
                    end
                end

                ACCUM: begin
                    if (beat) begin
                        acc_data <= sum_next;
                        ovf      <= ovf | sat_next;
                        count    <= count - CW'(1);
                        if (last_beat) begin
                            state     <= DONE;
                            p_ready   <= 1'b0;
                            acc_valid <= 1'b1;
                        end
                    end
                end

                DONE: begin
                    // Result and ovf stay put until the consumer takes them
                    // and then remain visible in IDLE until the next start.
                    if (acc_ready) begin
                        state     <= IDLE;
                        acc_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end

                default: begin
                    // Unused encoding: fall back to IDLE with quiet outputs.
                    state     <= IDLE;
                    p_ready   <= 1'b0;
                    acc_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
